// File: rtl/bus_controller_if.sv
// Bundle of CPU-side, external-bus and OAM write-port signals for bus_controller.
// The slave modport is the controller's own view. The master modport is the
// surrounding system's view: the CPU driving accesses and the external bus
// supplying read data.
interface bus_controller_if;
    logic [15:0] cpu_addr;
    logic        cpu_enable;
    logic        cpu_write;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic [15:0] ext_addr;
    logic        ext_enable;
    logic        ext_write;
    logic [7:0]  ext_wdata;
    logic [7:0]  ext_rdata;
    logic [7:0]  oam_addr;
    logic        oam_write;
    logic [7:0]  oam_wdata;
    logic        dma_active;

    modport slave (
        input  cpu_addr, cpu_enable, cpu_write, cpu_wdata, ext_rdata,
        output cpu_rdata, ext_addr, ext_enable, ext_write, ext_wdata,
        output oam_addr, oam_write, oam_wdata, dma_active
    );

    modport master (
        output cpu_addr, cpu_enable, cpu_write, cpu_wdata, ext_rdata,
        input  cpu_rdata, ext_addr, ext_enable, ext_write, ext_wdata,
        input  oam_addr, oam_write, oam_wdata, dma_active
    );
endinterface

// File: rtl/bus_controller.sv
// bus_controller: decodes CPU accesses to HRAM (FF80-FFFE), the OAM DMA
// register (FF46) or the external bus, and returns read data to the CPU.
// Define BUS_OAM_DMA_EN to build the OAM DMA engine. Without it, FF46 is an
// ordinary external address and the DMA outputs are tied off.
module bus_controller (
    input  logic             clk,
    input  logic             reset,
    bus_controller_if.slave  bus
);
    // T-cycle position inside the current M-cycle. Phase 3 is the last T-cycle.
    logic [1:0] phase;
    logic       commit;

    assign commit = (phase == 2'd3);

    // Advance the T-cycle phase. It stays in step with the CPU because both leave reset together.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) phase <= 2'd0;
        else       phase <= phase + 2'd1;
    end

    // ---------------------------------------------------------------- decode
    logic hram_sel;
    logic dma_sel;
    logic ext_sel;

    assign hram_sel = bus.cpu_enable && (bus.cpu_addr >= 16'hFF80) && (bus.cpu_addr != 16'hFFFF);
`ifdef BUS_OAM_DMA_EN
    assign dma_sel  = bus.cpu_enable && (bus.cpu_addr == 16'hFF46);
`else
    assign dma_sel  = 1'b0;
`endif
    assign ext_sel  = bus.cpu_enable && !hram_sel && !dma_sel;

    // ------------------------------------------------------------------ HRAM
    logic [7:0] hram [0:126];

    // Commit CPU writes to HRAM at the end of the M-cycle.
    // NOTE: memory arrays get no reset; their contents are undefined after power-up.
    always_ff @(posedge clk) begin
        if (commit && hram_sel && bus.cpu_write)
            hram[bus.cpu_addr[6:0]] <= bus.cpu_wdata;
    end

    // ------------------------------------------------------------ DMA engine
    logic        dma_on;        // DMA owns the external bus this M-cycle
    logic [7:0]  dma_reg;       // value returned by reads of FF46
    logic [15:0] dma_ext_addr;  // source address of the byte being copied

`ifdef BUS_OAM_DMA_EN
    typedef enum logic [1:0] {
        IDLE,
        START,
        ACTIVE
    } dma_state_t;

    dma_state_t state;
    logic [7:0] page;
    logic [7:0] idx;
    logic [7:0] src_page;
    logic       dma_wr;

    // Pages E0-FF would hit the echo area, so they fold back onto C000-DFFF.
    assign src_page = (page < 8'hE0) ? page : {3'b110, page[4:0]};
    assign dma_wr   = dma_sel && bus.cpu_write && commit;

    // DMA FSM: every transition happens on an M-cycle boundary. A write to FF46
    // always restarts the transfer, whatever state the engine is in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            page   <= 8'h00;
            idx    <= 8'h00;
            dma_on <= 1'b0;
        end else if (dma_wr) begin
            state  <= START;
            page   <= bus.cpu_wdata;
            idx    <= 8'h00;
            dma_on <= 1'b0;
        end else if (commit) begin
            case (state)
                START: begin
                    state  <= ACTIVE;
                    dma_on <= 1'b1;
                end
                ACTIVE: begin
                    if (idx == 8'd159) begin
                        state  <= IDLE;
                        idx    <= 8'h00;
                        dma_on <= 1'b0;
                    end else begin
                        idx <= idx + 8'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    dma_on <= 1'b0;
                end
            endcase
        end
    end

    assign dma_reg        = page;
    assign dma_ext_addr   = {src_page, idx};
    assign bus.oam_write  = dma_on && commit;
    assign bus.oam_addr   = bus.oam_write ? idx : 8'h00;
    assign bus.oam_wdata  = bus.oam_write ? bus.ext_rdata : 8'h00;
`else
    assign dma_on         = 1'b0;
    assign dma_reg        = 8'hFF;
    assign dma_ext_addr   = 16'h0000;
    assign bus.oam_write  = 1'b0;
    assign bus.oam_addr   = 8'h00;
    assign bus.oam_wdata  = 8'h00;
`endif

    assign bus.dma_active = dma_on;

    // ----------------------------------------------------------- external bus
    // Drive the external bus from the DMA engine while it owns the bus, otherwise from the CPU.
    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        bus.ext_addr   = 16'h0000;
        bus.ext_enable = 1'b0;
        bus.ext_write  = 1'b0;
        bus.ext_wdata  = 8'h00;
        if (dma_on) begin
            bus.ext_addr   = dma_ext_addr;
            bus.ext_enable = 1'b1;
        end else if (ext_sel) begin
            bus.ext_addr   = bus.cpu_addr;
            bus.ext_enable = 1'b1;
            bus.ext_write  = bus.cpu_write;
            bus.ext_wdata  = bus.cpu_wdata;
        end
    end

    // Return read data from the selected target. External reads see FF while DMA owns the bus.
    always_comb begin
        bus.cpu_rdata = 8'hFF;
        if (hram_sel)
            bus.cpu_rdata = hram[bus.cpu_addr[6:0]];
        else if (dma_sel)
            bus.cpu_rdata = dma_reg;
        else if (ext_sel && !dma_on)
            bus.cpu_rdata = bus.ext_rdata;
    end
endmodule

// File: tb/tb_bus_controller.sv
// Self-checking bench for bus_controller. The external bus model returns the
// low address byte. Expected OAM writes are queued when a DMA is started and
// are checked by a monitor as the pulses appear.
module tb_bus_controller;
    logic clk;
    logic reset;

    bus_controller_if bus ();

    bus_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External bus model: read data is the low byte of the address.
    assign bus.ext_rdata = bus.ext_addr[7:0];

    typedef struct {
        logic [7:0]  addr;
        logic [7:0]  data;
        logic [15:0] src;
    } oam_exp_t;

    oam_exp_t   exp_q[$];
    int         total = 0;
    int         bad   = 0;
    int         pulse_cnt = 0;
    logic [7:0] last_oam_addr = 8'h00;

    logic [15:0] s_ext_addr;
    logic        s_ext_enable;
    logic        s_ext_write;
    logic [7:0]  s_ext_wdata;

    // Monitor: every OAM write pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (!reset && bus.oam_write === 1'b1) begin
            pulse_cnt++;
            last_oam_addr = bus.oam_addr;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL oam_unexpected: got addr=%h data=%h, required no pulse", bus.oam_addr, bus.oam_wdata);
            end else begin
                oam_exp_t e;
                e = exp_q.pop_front();
                if (bus.oam_addr !== e.addr || bus.oam_wdata !== e.data || bus.ext_addr !== e.src) begin
                    bad++;
                    $display("FAIL oam_pulse: got addr=%h data=%h src=%h, required addr=%h data=%h src=%h",
                             bus.oam_addr, bus.oam_wdata, bus.ext_addr, e.addr, e.data, e.src);
                end
            end
        end
    end

    // Queue the 160 expected OAM writes for a transfer from the given page.
    task automatic push_dma(input logic [7:0] page);
        logic [7:0] sp;
        sp = (page < 8'hE0) ? page : {3'b110, page[4:0]};
        for (int i = 0; i < 160; i++) begin
            oam_exp_t e;
            e.addr = 8'(i);
            e.data = 8'(i);
            e.src  = {sp, 8'(i)};
            exp_q.push_back(e);
        end
    endtask

    // One CPU M-cycle access. Starts and ends just after an M-cycle boundary;
    // read data and external bus signals are sampled during phase 3.
    task automatic access(input logic [15:0] a, input logic wr, input logic [7:0] d,
                          output logic [7:0] rd);
        bus.cpu_addr   = a;
        bus.cpu_enable = 1'b1;
        bus.cpu_write  = wr;
        bus.cpu_wdata  = d;
        repeat (3) @(posedge clk);
        #1;
        rd           = bus.cpu_rdata;
        s_ext_addr   = bus.ext_addr;
        s_ext_enable = bus.ext_enable;
        s_ext_write  = bus.ext_write;
        s_ext_wdata  = bus.ext_wdata;
        @(posedge clk);
        #1;
        bus.cpu_enable = 1'b0;
        bus.cpu_write  = 1'b0;
    endtask

    task automatic idle_mcycles(input int n);
        repeat (4 * n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset          = 1'b1;
        bus.cpu_addr   = 16'h0000;
        bus.cpu_enable = 1'b0;
        bus.cpu_write  = 1'b0;
        bus.cpu_wdata  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (bus.dma_active !== 1'b0 || bus.oam_write !== 1'b0 || bus.oam_addr !== 8'h00 || bus.oam_wdata !== 8'h00) begin
            bad++;
            $display("FAIL reset_dma: got active=%b oam_write=%b oam_addr=%h oam_wdata=%h, required 0 0 00 00",
                     bus.dma_active, bus.oam_write, bus.oam_addr, bus.oam_wdata);
        end
        total++;
        if (bus.ext_enable !== 1'b0 || bus.ext_write !== 1'b0 || bus.ext_addr !== 16'h0000 || bus.ext_wdata !== 8'h00) begin
            bad++;
            $display("FAIL reset_ext: got en=%b wr=%b addr=%h wdata=%h, required 0 0 0000 00",
                     bus.ext_enable, bus.ext_write, bus.ext_addr, bus.ext_wdata);
        end
        total++;
        if (bus.cpu_rdata !== 8'hFF) begin
            bad++;
            $display("FAIL reset_rdata: got %h, required FF", bus.cpu_rdata);
        end
        // Release just after an edge so the next edge is the phase 0->1 step.
        reset = 1'b0;
    endtask

    task automatic test_hram;
        logic [7:0] rd;
        access(16'hFF80, 1'b1, 8'h5A, rd);
        total++;
        if (s_ext_enable !== 1'b0) begin
            bad++;
            $display("FAIL hram_write_ext: got ext_enable=%b, required 0", s_ext_enable);
        end
        access(16'hFF80, 1'b0, 8'h00, rd);
        total++;
        if (rd !== 8'h5A) begin
            bad++;
            $display("FAIL hram_read: got %h, required 5A", rd);
        end
        access(16'hFFFE, 1'b0, 8'h00, rd);
        total++;
        if (s_ext_enable !== 1'b0) begin
            bad++;
            $display("FAIL hram_top_ext: got ext_enable=%b, required 0", s_ext_enable);
        end
        access(16'hFFFE, 1'b1, 8'hA7, rd);
        access(16'hFFFE, 1'b0, 8'h00, rd);
        total++;
        if (rd !== 8'hA7) begin
            bad++;
            $display("FAIL hram_top_read: got %h, required A7", rd);
        end
    endtask

    task automatic test_ext;
        logic [7:0] rd;
        access(16'hC123, 1'b0, 8'h00, rd);
        total++;
        if (s_ext_addr !== 16'hC123 || s_ext_enable !== 1'b1 || s_ext_write !== 1'b0 || rd !== 8'h23) begin
            bad++;
            $display("FAIL ext_read: got addr=%h en=%b wr=%b rdata=%h, required C123 1 0 23",
                     s_ext_addr, s_ext_enable, s_ext_write, rd);
        end
        access(16'hFFFF, 1'b1, 8'h77, rd);
        total++;
        if (s_ext_addr !== 16'hFFFF || s_ext_enable !== 1'b1 || s_ext_write !== 1'b1 || s_ext_wdata !== 8'h77) begin
            bad++;
            $display("FAIL ext_write: got addr=%h en=%b wr=%b wdata=%h, required FFFF 1 1 77",
                     s_ext_addr, s_ext_enable, s_ext_write, s_ext_wdata);
        end
    endtask

`ifdef BUS_OAM_DMA_EN
    // Wait for dma_active to fall, counting clock edges since the call.
    task automatic wait_dma_done(output int edges, output bit ok);
        edges = 0;
        ok    = 1'b0;
        while (edges < 1000) begin
            @(posedge clk);
            #1;
            edges++;
            if (edges > 4 && bus.dma_active === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL dma_timeout: dma_active still %b after %0d edges, required 0", bus.dma_active, edges);
        end
    endtask

    task automatic test_dma;
        logic [7:0] rd;
        int         edges;
        bit         ok;
        pulse_cnt = 0;
        access(16'hFF46, 1'b1, 8'hC1, rd);
        push_dma(8'hC1);
        // M-cycle N+1: START, no DMA yet.
        total++;
        if (bus.dma_active !== 1'b0) begin
            bad++;
            $display("FAIL dma_start_active: got %b, required 0", bus.dma_active);
        end
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (bus.dma_active !== 1'b1 || bus.oam_write !== 1'b0 || pulse_cnt != 0) begin
            bad++;
            $display("FAIL dma_first_cycle: got active=%b oam_write=%b pulses=%0d, required 1 0 0",
                     bus.dma_active, bus.oam_write, pulse_cnt);
        end
        // Phase 3 of M-cycle N+2: first OAM write.
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bus.oam_write !== 1'b1 || bus.oam_addr !== 8'h00 || bus.oam_wdata !== 8'h00 || bus.ext_addr !== 16'hC100) begin
            bad++;
            $display("FAIL dma_first_pulse: got wr=%b addr=%h data=%h src=%h, required 1 00 00 C100",
                     bus.oam_write, bus.oam_addr, bus.oam_wdata, bus.ext_addr);
        end
        @(posedge clk);
        #1;
        // CPU accesses while DMA owns the bus.
        access(16'hC000, 1'b0, 8'h00, rd);
        total++;
        if (rd !== 8'hFF || s_ext_addr[15:8] !== 8'hC1 || s_ext_write !== 1'b0) begin
            bad++;
            $display("FAIL dma_cpu_read: got rdata=%h ext_addr=%h wr=%b, required FF C1xx 0", rd, s_ext_addr, s_ext_write);
        end
        access(16'hC000, 1'b1, 8'h55, rd);
        total++;
        if (s_ext_write !== 1'b0 || s_ext_addr[15:8] !== 8'hC1) begin
            bad++;
            $display("FAIL dma_cpu_write_dropped: got wr=%b ext_addr=%h, required 0 C1xx", s_ext_write, s_ext_addr);
        end
        access(16'hFF81, 1'b1, 8'h3C, rd);
        access(16'hFF81, 1'b0, 8'h00, rd);
        total++;
        if (rd !== 8'h3C) begin
            bad++;
            $display("FAIL dma_hram_rw: got %h, required 3C", rd);
        end
        access(16'hFF46, 1'b0, 8'h00, rd);
        total++;
        if (rd !== 8'hC1) begin
            bad++;
            $display("FAIL dma_reg_read: got %h, required C1", rd);
        end
        wait_dma_done(edges, ok);
        total++;
        if (pulse_cnt != 160 || last_oam_addr !== 8'h9F || exp_q.size() != 0) begin
            bad++;
            $display("FAIL dma_count: got pulses=%0d last=%h left=%0d, required 160 9F 0",
                     pulse_cnt, last_oam_addr, exp_q.size());
        end
        exp_q.delete();
        // Realign to an M-cycle boundary: the fall happens on one.
        #0;
    endtask

    task automatic test_echo;
        logic [7:0] rd;
        int         edges;
        bit         ok;
        pulse_cnt = 0;
        access(16'hFF46, 1'b1, 8'hF2, rd);
        push_dma(8'hF2);
        wait_dma_done(edges, ok);
        total++;
        if (edges != 644) begin
            bad++;
            $display("FAIL dma_latency: got %0d edges to dma_active fall, required 644", edges);
        end
        total++;
        if (pulse_cnt != 160 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL echo_count: got pulses=%0d left=%0d, required 160 0", pulse_cnt, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back;
        logic [7:0] rd;
        access(16'hFF46, 1'b1, 8'hC1, rd);
        push_dma(8'hC1);
        // START plus 50 ACTIVE M-cycles, so the restart lands on idx=50.
        idle_mcycles(51);
        access(16'hFF46, 1'b1, 8'h80, rd);
        total++;
        if (exp_q.size() != 109) begin
            bad++;
            $display("FAIL restart_idx: got %0d pending before restart, required 109", exp_q.size());
        end
        exp_q.delete();
        push_dma(8'h80);
        repeat (7) @(posedge clk);
        #1;
        total++;
        if (bus.oam_write !== 1'b1 || bus.oam_addr !== 8'h00 || bus.ext_addr !== 16'h8000) begin
            bad++;
            $display("FAIL restart_first: got wr=%b addr=%h src=%h, required 1 00 8000",
                     bus.oam_write, bus.oam_addr, bus.ext_addr);
        end
        @(posedge clk);
        #1;
        idle_mcycles(20);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        total++;
        if (bus.dma_active !== 1'b0 || bus.oam_write !== 1'b0 || bus.ext_enable !== 1'b0) begin
            bad++;
            $display("FAIL reset_abort: got active=%b oam_write=%b ext_en=%b, required 0 0 0",
                     bus.dma_active, bus.oam_write, bus.ext_enable);
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        pulse_cnt = 0;
        idle_mcycles(100);
        total++;
        if (pulse_cnt != 0 || bus.dma_active !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_pulses: got pulses=%0d active=%b, required 0 0", pulse_cnt, bus.dma_active);
        end
    endtask
`else
    task automatic test_no_dma;
        logic [7:0] rd;
        pulse_cnt = 0;
        access(16'hFF46, 1'b1, 8'hC1, rd);
        total++;
        if (s_ext_addr !== 16'hFF46 || s_ext_enable !== 1'b1 || s_ext_write !== 1'b1 || s_ext_wdata !== 8'hC1) begin
            bad++;
            $display("FAIL nodma_ext: got addr=%h en=%b wr=%b wdata=%h, required FF46 1 1 C1",
                     s_ext_addr, s_ext_enable, s_ext_write, s_ext_wdata);
        end
        access(16'hFF46, 1'b0, 8'h00, rd);
        total++;
        if (rd !== 8'h46) begin
            bad++;
            $display("FAIL nodma_read: got %h, required 46", rd);
        end
        idle_mcycles(10);
        total++;
        if (pulse_cnt != 0 || bus.dma_active !== 1'b0) begin
            bad++;
            $display("FAIL nodma_idle: got pulses=%0d active=%b, required 0 0", pulse_cnt, bus.dma_active);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_hram();
        test_ext();
`ifdef BUS_OAM_DMA_EN
        test_dma();
        test_echo();
        test_back_to_back();
`else
        test_no_dma();
`endif
        test_hram();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
